memory_stage_controller: RTL and testbench
==========================================

MEMORY_STAGE_CONTROLLER -- requirements
Module: memory_stage_controller

Interface
REQ-001 Parameters SHALL be: DATA_W, 16, data word width; SP_W, 32, stack pointer width; ADDR_W, 16, data memory address width (ADDR_W <= SP_W); SP_INIT, 32'h0000_FFFF, stack pointer reset value.
REQ-002 Ports SHALL be: clk in 1 clock; reset in 1 synchronous active-high reset; one clock, all state on rising clk edge.
REQ-003 op in 3 memory op from EM register (0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL32, 6 RET32, 7 reserved = NOP); flush in 1 cancel op.
REQ-004 result_in in DATA_W ALU result; address_in in DATA_W effective address; reg_dst_num_in in 4; reg_dst_value_in in DATA_W store/push data; pc_in in SP_W return PC; wb_en_in in 1.
REQ-005 mem_addr out ADDR_W; mem_wdata out DATA_W; mem_we out 1; mem_re out 1; mem_rdata in DATA_W (asynchronous read, same-cycle data).
REQ-006 stall out 1 hold upstream; sp_out out SP_W current SP; wb_en_out out 1; reg_dst_num_out out 4; wb_data_out out DATA_W; pc_load out 1; pc_out out SP_W; stack_exc out 1.

Function
REQ-007 FSM SHALL have states IDLE and SECOND; single-word ops complete in IDLE.
REQ-008 LOAD: mem_re=1, mem_addr=address_in[ADDR_W-1:0]; next edge wb_data_out=mem_rdata, wb_en_out=wb_en_in.
REQ-009 STORE: mem_we=1, mem_addr=address_in, mem_wdata=reg_dst_value_in; next edge wb_en_out=0.
REQ-010 ALU ops/NOP with wb_en_in: next edge wb_data_out=result_in; memory strobes 0.
REQ-011 PUSH (full-descending): write reg_dst_value_in at SP, SP<=SP-1; POP: read at SP+1, SP<=SP+1, wb_data_out=mem_rdata.
REQ-012 CALL32 in IDLE: write pc_in[31:16] at SP, SP<=SP-1, stall=1, go SECOND; SECOND: write pc_in[15:0] at SP, SP<=SP-1, stall=0, go IDLE.
REQ-013 RET32 in IDLE: read SP+1 (low word) into internal hold reg, SP<=SP+1, stall=1, go SECOND; SECOND: read SP+1 (high), SP<=SP+1, next edge pc_load=1 pulse, pc_out={high,low}.
REQ-014 stall SHALL be combinational, high only in IDLE with op CALL32/RET32 and flush=0; upstream holds op/operands stable while stall=1.
REQ-015 Registered outputs SHALL present a bubble (wb_en_out=0, pc_load=0) after any stall cycle.
REQ-016 flush in IDLE SHALL force NOP (no strobes, SP unchanged); flush in SECOND SHALL be ignored (two-word op completes).
REQ-017 mem_addr for stack ops SHALL be the low ADDR_W bits of SP or SP+1; SP arithmetic modulo 2^SP_W.
REQ-018 mem_we and mem_re SHALL never both be 1; at most one memory access per cycle.
REQ-019 sp_out SHALL equal the SP register (post-update visible the cycle after the edge).

Reset
REQ-020 reset SHALL force state IDLE, SP=SP_INIT, hold reg=0, and all registered outputs 0 (wb_en_out, reg_dst_num_out, wb_data_out, pc_load, pc_out, stack_exc).
REQ-021 reset in SECOND SHALL abandon the op: no second access, SP=SP_INIT.
REQ-022 Combinational strobes (mem_we, mem_re, stall) SHALL be 0 while reset=1.

Configuration
REQ-023 Macro STACK_OVERFLOW_CHECK_EN: when defined, a push/CALL32 word at SP==0 or a pop/RET32 word with SP==SP_INIT SHALL suppress that access, leave SP unchanged, set sticky stack_exc=1 until reset, and abort to IDLE.
REQ-024 When undefined, stack_exc SHALL be tied 0 and SP SHALL wrap freely.

Structure
REQ-025 Op encodings, state enum, and DATA_W/SP_W defaults SHALL live in the shared pipeline package.
REQ-026 One sub-module stack_pointer_unit (SP register, +1/-1, overflow check) SHALL be instantiated; rest stays in this module.

Verification
REQ-027 Reset then PUSH value 16'hABCD -> mem write at 16'hFFFF, data ABCD; sp_out=32'h0000_FFFE.
REQ-028 POP after REQ-027 -> read at 16'hFFFF, wb_data_out=ABCD one cycle later, sp_out=32'h0000_FFFF.
REQ-029 CALL32 pc_in=32'h1234_5678 -> stall high 1 cycle; writes 1234 at FFFF, 5678 at FFFE; sp_out=32'h0000_FFFD.
REQ-030 RET32 after REQ-029 -> reads FFFE then FFFF; pc_load 1-cycle pulse with pc_out=32'h1234_5678; sp_out back to 32'h0000_FFFF.
REQ-031 LOAD address_in=16'h0010 with mem_rdata=16'h00AA, then STORE same cycle after -> wb_data_out=00AA; store strobe only on STORE cycle, wb_en_out=0 after.
REQ-032 reset asserted in SECOND of CALL32; and (with STACK_OVERFLOW_CHECK_EN) POP at SP_INIT -> no second write, all outputs 0; stack_exc=1, SP unchanged.

Source files
------------

// File: rtl/memory_stage_controller_pkg.sv
// Shared pipeline definitions for the memory stage: default widths,
// memory-op encodings and the two-state controller sequence.
package memory_stage_controller_pkg;

   localparam int          DATA_W_DEF  = 16;
   localparam int          SP_W_DEF    = 32;
   localparam int          ADDR_W_DEF  = 16;
   localparam logic [31:0] SP_INIT_DEF = 32'h0000_FFFF;

   // Memory op field carried in the EM pipeline register
   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_LOAD   = 3'd1,
      OP_STORE  = 3'd2,
      OP_PUSH   = 3'd3,
      OP_POP    = 3'd4,
      OP_CALL32 = 3'd5,
      OP_RET32  = 3'd6,
      OP_RSVD   = 3'd7
   } op_e;

   // IDLE handles single-word ops; SECOND finishes CALL32/RET32
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SECOND = 1'b1
   } state_e;

endpackage

// File: rtl/memory_stage_controller_if.sv
// Data-memory bus between the memory stage (master) and the data RAM
// (slave). Read data is combinational: valid in the same cycle as the
// address.
interface memory_stage_controller_if
   import memory_stage_controller_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_we,
      output mem_re,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_we,
      input  mem_re,
      output mem_rdata
   );
endinterface

// File: rtl/memory_stage_controller_stack_pointer_unit.sv
// Stack pointer for a full-descending stack: holds SP, steps it by one
// in either direction and provides the pop address (SP+1).
// Optional: STACK_OVERFLOW_CHECK_EN flags a push at SP==0 and a pop at
// SP==SP_INIT as blocked; without it the blocks are tied low and SP wraps.
module stack_pointer_unit
   import memory_stage_controller_pkg::*;
#(
   parameter int              SP_W    = SP_W_DEF,
   parameter int              ADDR_W  = ADDR_W_DEF,
   parameter logic [SP_W-1:0] SP_INIT = SP_INIT_DEF
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_inc,
   input  logic              i_dec,
   output logic [SP_W-1:0]   o_sp,
   output logic [ADDR_W-1:0] o_pop_addr,
   output logic              o_push_blk,
   output logic              o_pop_blk
);
   localparam logic [SP_W-1:0]   SP_ONE   = {{(SP_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [SP_W-1:0] r_sp;

   // SP register: reset to SP_INIT, otherwise step once per cycle (mod 2^SP_W)
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sp <= SP_INIT;
      end else if (i_inc && !i_dec) begin
         r_sp <= r_sp + SP_ONE;
      end else if (i_dec && !i_inc) begin
         r_sp <= r_sp - SP_ONE;
      end else begin
         r_sp <= r_sp;
      end
   end

   assign o_sp = r_sp;
   // Low bits of SP+1 equal the low bits of SP plus one modulo 2^ADDR_W
   assign o_pop_addr = r_sp[ADDR_W-1:0] + ADDR_ONE;

`ifdef STACK_OVERFLOW_CHECK_EN
   assign o_push_blk = (r_sp == {SP_W{1'b0}});
   assign o_pop_blk  = (r_sp == SP_INIT);
`else
   assign o_push_blk = 1'b0;
   assign o_pop_blk  = 1'b0;
`endif

endmodule

// File: rtl/memory_stage_controller.sv
// Memory stage of the pipeline: loads/stores, single-word push/pop and
// two-word CALL32/RET32 sequenced by a small IDLE/SECOND FSM.
// Optional: STACK_OVERFLOW_CHECK_EN suppresses out-of-range stack
// accesses and raises a sticky o_stack_exc.
// Assumes SP_W == 2*DATA_W (return PC is stored as two stack words) and
// ADDR_W <= DATA_W.
module memory_stage_controller
   import memory_stage_controller_pkg::*;
#(
   parameter int              DATA_W  = DATA_W_DEF,
   parameter int              SP_W    = SP_W_DEF,
   parameter int              ADDR_W  = ADDR_W_DEF,
   parameter logic [SP_W-1:0] SP_INIT = SP_INIT_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [2:0]           i_op,
   input  logic                 i_flush,
   input  logic [DATA_W-1:0]    i_result,
   input  logic [DATA_W-1:0]    i_address,
   input  logic [3:0]           i_reg_dst_num,
   input  logic [DATA_W-1:0]    i_reg_dst_value,
   input  logic [SP_W-1:0]      i_pc,
   input  logic                 i_wb_en,
   memory_stage_controller_if.master bus,
   output logic                 o_stall,
   output logic [SP_W-1:0]      o_sp,
   output logic                 o_wb_en,
   output logic [3:0]           o_reg_dst_num,
   output logic [DATA_W-1:0]    o_wb_data,
   output logic                 o_pc_load,
   output logic [SP_W-1:0]      o_pc,
   output logic                 o_stack_exc
);

   state_e            r_state, w_state_nxt;
   logic              r_second_ret, w_second_ret_nxt;
   logic [DATA_W-1:0] r_hold, w_hold_nxt;

   logic              r_wb_en, w_wb_en_nxt;
   logic [3:0]        r_reg_dst_num;
   logic [DATA_W-1:0] r_wb_data, w_wb_data_nxt;
   logic              r_pc_load, w_pc_load_nxt;
   logic [SP_W-1:0]   r_pc, w_pc_nxt;
   logic              r_stack_exc, w_exc_set;

   logic              w_mem_we, w_mem_re, w_stall;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;

   logic              w_sp_inc, w_sp_dec;
   logic [SP_W-1:0]   w_sp;
   logic [ADDR_W-1:0] w_pop_addr;
   logic              w_push_blk, w_pop_blk;

   stack_pointer_unit #(
      .SP_W    (SP_W),
      .ADDR_W  (ADDR_W),
      .SP_INIT (SP_INIT)
   ) u_spu (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_inc      (w_sp_inc),
      .i_dec      (w_sp_dec),
      .o_sp       (w_sp),
      .o_pop_addr (w_pop_addr),
      .o_push_blk (w_push_blk),
      .o_pop_blk  (w_pop_blk)
   );

   // Next state, memory strobes, SP steps and next registered outputs
   always_comb begin
      w_state_nxt      = r_state;
      w_second_ret_nxt = r_second_ret;
      w_hold_nxt       = r_hold;
      w_mem_we         = 1'b0;
      w_mem_re         = 1'b0;
      w_mem_addr       = '0;
      w_mem_wdata      = '0;
      w_stall          = 1'b0;
      w_sp_inc         = 1'b0;
      w_sp_dec         = 1'b0;
      w_wb_en_nxt      = 1'b0;
      w_wb_data_nxt    = r_wb_data;
      w_pc_load_nxt    = 1'b0;
      w_pc_nxt         = r_pc;
      w_exc_set        = 1'b0;
      if (i_reset) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_flush) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  case (op_e'(i_op))
                     OP_LOAD: begin
                        w_mem_re      = 1'b1;
                        w_mem_addr    = i_address[ADDR_W-1:0];
                        w_wb_en_nxt   = i_wb_en;
                        w_wb_data_nxt = bus.mem_rdata;
                     end
                     OP_STORE: begin
                        w_mem_we    = 1'b1;
                        w_mem_addr  = i_address[ADDR_W-1:0];
                        w_mem_wdata = i_reg_dst_value;
                     end
                     OP_PUSH: begin
                        if (w_push_blk) begin
                           w_exc_set = 1'b1;
                        end else begin
                           w_mem_we    = 1'b1;
                           w_mem_addr  = w_sp[ADDR_W-1:0];
                           w_mem_wdata = i_reg_dst_value;
                           w_sp_dec    = 1'b1;
                        end
                     end
                     OP_POP: begin
                        if (w_pop_blk) begin
                           w_exc_set = 1'b1;
                        end else begin
                           w_mem_re      = 1'b1;
                           w_mem_addr    = w_pop_addr;
                           w_sp_inc      = 1'b1;
                           w_wb_en_nxt   = i_wb_en;
                           w_wb_data_nxt = bus.mem_rdata;
                        end
                     end
                     OP_CALL32: begin
                        // High word first; low word is parked for SECOND
                        if (w_push_blk) begin
                           w_exc_set = 1'b1;
                        end else begin
                           w_mem_we         = 1'b1;
                           w_mem_addr       = w_sp[ADDR_W-1:0];
                           w_mem_wdata      = i_pc[SP_W-1:SP_W-DATA_W];
                           w_sp_dec         = 1'b1;
                           w_stall          = 1'b1;
                           w_hold_nxt       = i_pc[DATA_W-1:0];
                           w_second_ret_nxt = 1'b0;
                           w_state_nxt      = ST_SECOND;
                        end
                     end
                     OP_RET32: begin
                        // Low word pops first and is parked for SECOND
                        if (w_pop_blk) begin
                           w_exc_set = 1'b1;
                        end else begin
                           w_mem_re         = 1'b1;
                           w_mem_addr       = w_pop_addr;
                           w_sp_inc         = 1'b1;
                           w_stall          = 1'b1;
                           w_hold_nxt       = bus.mem_rdata;
                           w_second_ret_nxt = 1'b1;
                           w_state_nxt      = ST_SECOND;
                        end
                     end
                     default: begin
                        // NOP, ALU results and the reserved encoding
                        w_wb_en_nxt   = i_wb_en;
                        w_wb_data_nxt = i_result;
                     end
                  endcase
               end
            end
            ST_SECOND: begin
               // Flush is ignored here: the two-word op always finishes
               w_state_nxt = ST_IDLE;
               if (r_second_ret) begin
                  if (w_pop_blk) begin
                     w_exc_set = 1'b1;
                  end else begin
                     w_mem_re      = 1'b1;
                     w_mem_addr    = w_pop_addr;
                     w_sp_inc      = 1'b1;
                     w_pc_load_nxt = 1'b1;
                     w_pc_nxt      = SP_W'({bus.mem_rdata, r_hold});
                  end
               end else begin
                  if (w_push_blk) begin
                     w_exc_set = 1'b1;
                  end else begin
                     w_mem_we    = 1'b1;
                     w_mem_addr  = w_sp[ADDR_W-1:0];
                     w_mem_wdata = r_hold;
                     w_sp_dec    = 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // FSM state, parked stack word and registered pipeline outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_second_ret  <= 1'b0;
         r_hold        <= '0;
         r_wb_en       <= 1'b0;
         r_reg_dst_num <= 4'd0;
         r_wb_data     <= '0;
         r_pc_load     <= 1'b0;
         r_pc          <= '0;
         r_stack_exc   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_second_ret  <= w_second_ret_nxt;
         r_hold        <= w_hold_nxt;
         r_wb_en       <= w_wb_en_nxt;
         r_reg_dst_num <= i_reg_dst_num;
         r_wb_data     <= w_wb_data_nxt;
         r_pc_load     <= w_pc_load_nxt;
         r_pc          <= w_pc_nxt;
         r_stack_exc   <= r_stack_exc | w_exc_set;
      end
   end

   assign bus.mem_we    = w_mem_we;
   assign bus.mem_re    = w_mem_re;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;

   assign o_stall       = w_stall;
   assign o_sp          = w_sp;
   assign o_wb_en       = r_wb_en;
   assign o_reg_dst_num = r_reg_dst_num;
   assign o_wb_data     = r_wb_data;
   assign o_pc_load     = r_pc_load;
   assign o_pc          = r_pc;
   assign o_stack_exc   = r_stack_exc;

endmodule

// File: tb/tb_memory_stage_controller.sv
// Self-checking bench for memory_stage_controller: a transaction-level
// stack/memory model predicts every cycle's strobes and registered
// outputs; a negedge process compares, plus literal spot checks.
module tb_memory_stage_controller;
   import memory_stage_controller_pkg::*;

   localparam logic [31:0] SP_RST = 32'h0000_FFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, flush, wb_en_in;
   logic [2:0]  op;
   logic [15:0] result, address, dst_val;
   logic [3:0]  dst_num;
   logic [31:0] pc_in;
   logic        stall, wb_en_out, pc_load, stack_exc;
   logic [31:0] sp_out, pc_out;
   logic [3:0]  dst_out;
   logic [15:0] wb_data;

   memory_stage_controller_if #(.DATA_W(16), .ADDR_W(16)) mif ();

   // Data RAM with combinational read
   logic [15:0] mem [0:65535];
   assign mif.mem_rdata = mem[mif.mem_addr];
   always @(posedge clk) if (mif.mem_we) mem[mif.mem_addr] <= mif.mem_wdata;

   memory_stage_controller dut (
      .i_clk(clk), .i_reset(reset), .i_op(op), .i_flush(flush),
      .i_result(result), .i_address(address), .i_reg_dst_num(dst_num),
      .i_reg_dst_value(dst_val), .i_pc(pc_in), .i_wb_en(wb_en_in),
      .bus(mif), .o_stall(stall), .o_sp(sp_out), .o_wb_en(wb_en_out),
      .o_reg_dst_num(dst_out), .o_wb_data(wb_data), .o_pc_load(pc_load),
      .o_pc(pc_out), .o_stack_exc(stack_exc)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;

   // Expectations for the current cycle
   logic        e_we, e_re, e_stall, e_wb_en, e_pc_load, e_exc;
   logic [15:0] e_addr, e_wdata, e_wb_data;
   logic [31:0] e_sp, e_pc;
   logic [3:0]  e_dst;
   // Registered outputs expected after the coming edge
   logic        nx_wb_en, nx_pc_load;
   logic [15:0] nx_wb_data;
   logic [31:0] nx_pc;
   logic [3:0]  nx_dst;
   // Architectural model state
   logic [31:0] m_sp;
   logic        m_exc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_on) begin
         chk("mem_we", 64'(mif.mem_we), 64'(e_we));
         chk("mem_re", 64'(mif.mem_re), 64'(e_re));
         chk("stall", 64'(stall), 64'(e_stall));
         if (e_we || e_re) chk("mem_addr", 64'(mif.mem_addr), 64'(e_addr));
         if (e_we) chk("mem_wdata", 64'(mif.mem_wdata), 64'(e_wdata));
         chk("sp_out", 64'(sp_out), 64'(e_sp));
         chk("wb_en_out", 64'(wb_en_out), 64'(e_wb_en));
         chk("pc_load", 64'(pc_load), 64'(e_pc_load));
         chk("stack_exc", 64'(stack_exc), 64'(e_exc));
         if (e_wb_en) begin
            chk("wb_data_out", 64'(wb_data), 64'(e_wb_data));
            chk("reg_dst_num_out", 64'(dst_out), 64'(e_dst));
         end
         if (e_pc_load) chk("pc_out", 64'(pc_out), 64'(e_pc));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      e_sp      = m_sp;
      e_exc     = m_exc;
      e_wb_en   = nx_wb_en;
      e_wb_data = nx_wb_data;
      e_dst     = nx_dst;
      e_pc_load = nx_pc_load;
      e_pc      = nx_pc;
   endtask

   task automatic cyc_defaults();
      e_we = 1'b0; e_re = 1'b0; e_stall = 1'b0; e_addr = 16'h0; e_wdata = 16'h0;
      nx_wb_en = 1'b0; nx_pc_load = 1'b0; nx_dst = dst_num;
   endtask

   task automatic do_reset();
      reset = 1'b1; op = 3'd0; flush = 1'b0; wb_en_in = 1'b0; dst_num = 4'd0;
      cyc_defaults();
      m_sp = SP_RST; m_exc = 1'b0;
      nx_wb_data = 16'h0; nx_pc = 32'h0;
      step();
      chk_on = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic t_alu(input logic [2:0] o, input logic [15:0] res, input logic we, input logic [3:0] dn);
      op = o; flush = 1'b0; result = res; wb_en_in = we; dst_num = dn;
      cyc_defaults();
      nx_wb_en = we; nx_wb_data = res;
      step();
   endtask

   task automatic t_load(input logic [15:0] a, input logic [3:0] dn);
      op = 3'd1; flush = 1'b0; address = a; wb_en_in = 1'b1; dst_num = dn;
      cyc_defaults();
      e_re = 1'b1; e_addr = a; nx_wb_en = 1'b1; nx_wb_data = mem[a];
      step();
   endtask

   task automatic t_store(input logic [15:0] a, input logic [15:0] v);
      op = 3'd2; flush = 1'b0; address = a; dst_val = v; wb_en_in = 1'b1;
      cyc_defaults();
      e_we = 1'b1; e_addr = a; e_wdata = v;
      step();
   endtask

   task automatic t_push(input logic [15:0] v, input logic fl);
      op = 3'd3; flush = fl; dst_val = v; wb_en_in = 1'b0;
      cyc_defaults();
      if (!fl) begin
`ifdef STACK_OVERFLOW_CHECK_EN
         if (m_sp == 32'd0) m_exc = 1'b1; else
`endif
         begin
            e_we = 1'b1; e_addr = m_sp[15:0]; e_wdata = v; m_sp = m_sp - 32'd1;
         end
      end
      step();
      flush = 1'b0;
   endtask

   task automatic t_pop(input logic [3:0] dn);
      logic [15:0] a;
      op = 3'd4; flush = 1'b0; wb_en_in = 1'b1; dst_num = dn;
      cyc_defaults();
`ifdef STACK_OVERFLOW_CHECK_EN
      if (m_sp == SP_RST) m_exc = 1'b1; else
`endif
      begin
         a = m_sp[15:0] + 16'd1;
         e_re = 1'b1; e_addr = a; nx_wb_en = 1'b1; nx_wb_data = mem[a];
         m_sp = m_sp + 32'd1;
      end
      step();
   endtask

   // CALL32; optional flush or reset during the second cycle
   task automatic t_call(input logic [31:0] pc, input logic fl2, input logic rst2);
      op = 3'd5; flush = 1'b0; pc_in = pc; wb_en_in = 1'b1;
      cyc_defaults();
      e_stall = 1'b1; e_we = 1'b1; e_addr = m_sp[15:0]; e_wdata = pc[31:16];
      m_sp = m_sp - 32'd1;
      step();
      cyc_defaults();
      flush = fl2;
      if (rst2) begin
         reset = 1'b1; m_sp = SP_RST; m_exc = 1'b0;
         nx_wb_data = 16'h0; nx_dst = 4'd0; nx_pc = 32'h0;
      end else begin
         e_we = 1'b1; e_addr = m_sp[15:0]; e_wdata = pc[15:0];
         m_sp = m_sp - 32'd1;
      end
      step();
      reset = 1'b0; flush = 1'b0;
   endtask

   task automatic t_ret();
      logic [15:0] a, lo, hi;
      op = 3'd6; flush = 1'b0; wb_en_in = 1'b1;
      cyc_defaults();
      a = m_sp[15:0] + 16'd1;
      e_stall = 1'b1; e_re = 1'b1; e_addr = a; lo = mem[a];
      m_sp = m_sp + 32'd1;
      step();
      cyc_defaults();
      a = m_sp[15:0] + 16'd1;
      e_re = 1'b1; e_addr = a; hi = mem[a];
      m_sp = m_sp + 32'd1;
      nx_pc_load = 1'b1; nx_pc = {hi, lo};
      step();
   endtask

   initial begin
      reset = 1'b1; op = 3'd0; flush = 1'b0; result = 16'h0; address = 16'h0;
      dst_val = 16'h0; dst_num = 4'd0; pc_in = 32'h0; wb_en_in = 1'b0;
      do_reset();
      chk("rst_sp", 64'(sp_out), 64'h0000_FFFF);
      chk("rst_wb_en", 64'(wb_en_out), 64'h0);
      chk("rst_wb_data", 64'(wb_data), 64'h0);
      chk("rst_dst", 64'(dst_out), 64'h0);
      chk("rst_pc", 64'(pc_out), 64'h0);
      chk("rst_pc_load", 64'(pc_load), 64'h0);
      chk("rst_exc", 64'(stack_exc), 64'h0);

      t_push(16'hABCD, 1'b0);
      chk("push_mem", 64'(mem[16'hFFFF]), 64'hABCD);
      chk("push_sp", 64'(sp_out), 64'h0000_FFFE);
      t_pop(4'd2);
      chk("pop_data", 64'(wb_data), 64'hABCD);
      chk("pop_sp", 64'(sp_out), 64'h0000_FFFF);

      t_call(32'h1234_5678, 1'b0, 1'b0);
      chk("call_hi", 64'(mem[16'hFFFF]), 64'h1234);
      chk("call_lo", 64'(mem[16'hFFFE]), 64'h5678);
      chk("call_sp", 64'(sp_out), 64'h0000_FFFD);
      t_ret();
      chk("ret_pc_load", 64'(pc_load), 64'h1);
      chk("ret_pc", 64'(pc_out), 64'h1234_5678);
      chk("ret_sp", 64'(sp_out), 64'h0000_FFFF);

      t_store(16'h0010, 16'h00AA);
      t_load(16'h0010, 4'd3);
      chk("load_data", 64'(wb_data), 64'h00AA);
      t_store(16'h0010, 16'h5555);
      chk("store_wb_en", 64'(wb_en_out), 64'h0);
      chk("store_mem", 64'(mem[16'h0010]), 64'h5555);
      t_alu(3'd0, 16'h7777, 1'b1, 4'd4);
      t_alu(3'd7, 16'h0001, 1'b0, 4'd5);
      t_alu(3'd7, 16'h2222, 1'b1, 4'd6);

      t_push(16'h1111, 1'b1);
      chk("flush_sp", 64'(sp_out), 64'h0000_FFFF);
      t_call(32'hCAFE_F00D, 1'b1, 1'b0);
      t_ret();
      chk("ret2_pc", 64'(pc_out), 64'hCAFE_F00D);

      t_push(16'h0101, 1'b0);
      t_push(16'h0202, 1'b0);
      t_pop(4'd7);
      t_pop(4'd8);
      chk("pops_data", 64'(wb_data), 64'h0101);

      t_call(32'hDEAD_BEEF, 1'b0, 1'b1);
      chk("rstcall_hi", 64'(mem[16'hFFFF]), 64'hDEAD);
      chk("rstcall_lo", 64'(mem[16'hFFFE]), 64'h0202);
      chk("rstcall_sp", 64'(sp_out), 64'h0000_FFFF);
      chk("rstcall_pc", 64'(pc_out), 64'h0);
      t_alu(3'd0, 16'h3333, 1'b1, 4'd1);

`ifdef STACK_OVERFLOW_CHECK_EN
      t_pop(4'd9);
      chk("ovf_exc", 64'(stack_exc), 64'h1);
      chk("ovf_sp", 64'(sp_out), 64'h0000_FFFF);
      t_alu(3'd0, 16'h4444, 1'b1, 4'd2);
`endif

      t_alu(3'd0, 16'h0000, 1'b0, 4'd0);
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
